// File: rtl/delta_order_responder_pkg.sv
// Shared types and default constants for the delta-order responder.
package delta_order_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    REPORT
  } state_t;

  localparam int unsigned DEF_X0  = 10;
  localparam int unsigned DEF_Y0  = 20;
  localparam int unsigned DEF_Z0  = 30;
  localparam int unsigned DEF_MUL = 10;
  localparam int unsigned DEF_ADD = 100;

endpackage

// File: rtl/delta_order_responder_if.sv
// Trigger and result handshakes; master drives requests, slave is the responder.
interface delta_order_responder_if;

  logic trig_valid;
  logic trig_ready;
  logic res_valid;
  logic res_ready;

  modport master (
    output trig_valid,
    output res_ready,
    input  trig_ready,
    input  res_valid
  );

  modport slave (
    input  trig_valid,
    input  res_ready,
    output trig_ready,
    output res_valid
  );

endinterface

// File: rtl/delta_order_responder_alu.sv
// Next-value unit: every output is computed from the old x/y/z only.
module delta_order_alu
  import delta_order_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned X0  = DEF_X0,
  parameter int unsigned Y0  = DEF_Y0,
  parameter int unsigned Z0  = DEF_Z0,
  parameter int unsigned MUL = DEF_MUL,
  parameter int unsigned ADD = DEF_ADD
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic         step,
  output logic [W-1:0] x_next,
  output logic [W-1:0] y_next,
  output logic [W-1:0] z_next,
  output logic [W-1:0] checksum_next
);

  localparam logic [W-1:0] SEED_X = W'(X0);
  localparam logic [W-1:0] SEED_Y = W'(Y0);
  localparam logic [W-1:0] SEED_Z = W'(Z0);
  localparam logic [W-1:0] K_MUL  = W'(MUL);
  localparam logic [W-1:0] K_ADD  = W'(ADD);

  always_comb begin
    x_next = SEED_X;
    y_next = SEED_Y;
    z_next = SEED_Z;
    if (step) begin
      x_next = y + z;
      y_next = x * K_MUL;
      z_next = x + K_ADD;
    end
    checksum_next = x_next ^ y_next ^ z_next;
  end

endmodule

// File: rtl/delta_order_responder.sv
// Trigger-driven x/y/z update engine with one-cycle EXEC and a stallable REPORT.
module delta_order_responder
  import delta_order_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned X0    = DEF_X0,
  parameter int unsigned Y0    = DEF_Y0,
  parameter int unsigned Z0    = DEF_Z0,
  parameter int unsigned MUL   = DEF_MUL,
  parameter int unsigned ADD   = DEF_ADD,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  delta_order_responder_if.slave bus,
  output logic [W-1:0]         x,
  output logic [W-1:0]         y,
  output logic [W-1:0]         z,
  output logic                 step,
  output logic [CNT_W-1:0]     trig_cnt,
  output logic [W-1:0]         checksum
);

  state_t state, state_next;
  logic [W-1:0] x_n, y_n, z_n, chk_n;

  delta_order_alu #(
    .W   (W),
    .X0  (X0),
    .Y0  (Y0),
    .Z0  (Z0),
    .MUL (MUL),
    .ADD (ADD)
  ) u_alu (
    .x             (x),
    .y             (y),
    .z             (z),
    .step          (step),
    .x_next        (x_n),
    .y_next        (y_n),
    .z_next        (z_n),
    .checksum_next (chk_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.trig_valid) state_next = EXEC;
      EXEC:    state_next = REPORT;
      REPORT:  if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.trig_ready = (state == IDLE);
    bus.res_valid  = (state == REPORT);
  end

  // Registers commit only at the end of EXEC, so REPORT always shows a stable step result.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      step     <= 1'b0;
      trig_cnt <= '0;
      checksum <= '0;
    end else if (state == EXEC) begin
      x        <= x_n;
      y        <= y_n;
      z        <= z_n;
      step     <= 1'b1;
      trig_cnt <= trig_cnt + 1'b1;
      checksum <= chk_n;
    end
  end

endmodule
